// File: rtl/mode_counter.sv
// ---------------------------------------------------------------------------
// mode_counter
//
// Prescaled counter with four counting behaviours selected by 'mode':
//   00 up with wrap to 0, 01 down with wrap to COUNT_LIMIT,
//   10 up/down bounce between 0 and COUNT_LIMIT, 11 one-shot up to COUNT_LIMIT.
// A count step happens once every CLOCK_DELAY enabled clock cycles.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   prescaler / count enable
//   mode      in   [1:0] counting behaviour select
//   load      in   synchronous load strobe (wins over a step)
//   load_val  in   [COUNT_WIDTH-1:0] load value, clamped to COUNT_LIMIT
//   count     out  [COUNT_WIDTH-1:0] registered count
//   dir       out  registered direction, 0 up / 1 down
//   tick      out  one-cycle pulse, count changed on the previous edge
//   wrap      out  one-cycle pulse, terminal event on the previous edge
//   done      out  level, one-shot reached COUNT_LIMIT
// ---------------------------------------------------------------------------
module mode_counter #(
    parameter int COUNT_WIDTH = 4,
    parameter int COUNT_LIMIT = 9,
    parameter int CLOCK_DELAY = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_val,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   dir,
    output logic                   tick,
    output logic                   wrap,
    output logic                   done
);

    localparam int PRESC_WIDTH = (CLOCK_DELAY > 1) ? $clog2(CLOCK_DELAY) : 1;
    localparam logic [PRESC_WIDTH-1:0] PRESC_LAST = PRESC_WIDTH'(CLOCK_DELAY - 1);
    localparam logic [COUNT_WIDTH-1:0] LIMIT      = COUNT_WIDTH'(COUNT_LIMIT);
    localparam logic [COUNT_WIDTH-1:0] ONE        = COUNT_WIDTH'(1);

    localparam logic [1:0] MODE_UP      = 2'b00;
    localparam logic [1:0] MODE_DOWN    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    // Illegal parameter combinations stop elaboration.
    if (COUNT_LIMIT > (2 ** COUNT_WIDTH) - 1) begin : g_bad_limit
        $error("mode_counter: COUNT_LIMIT does not fit in COUNT_WIDTH bits");
    end
    if (CLOCK_DELAY < 1) begin : g_bad_delay
        $error("mode_counter: CLOCK_DELAY must be at least 1");
    end

    logic [PRESC_WIDTH-1:0] presc;
    logic                   step;
    logic [COUNT_WIDTH-1:0] load_clamped;
    logic [COUNT_WIDTH-1:0] step_count;
    logic                   step_dir;
    logic                   step_wrap;
    logic                   step_done;

    // A load in the same cycle swallows the step and restarts the prescaler.
    assign step         = en & ~load & (presc == PRESC_LAST);
    assign load_clamped = (load_val > LIMIT) ? LIMIT : load_val;

    // Next count/direction and terminal-event flags if this edge is a step.
    always_comb begin
        step_count = count;
        step_dir   = dir;
        step_wrap  = 1'b0;
        step_done  = 1'b0;
        case (mode)
            MODE_UP: begin
                if (count == LIMIT) begin
                    step_count = '0;
                    step_wrap  = 1'b1;
                end else begin
                    step_count = count + ONE;
                end
            end
            MODE_DOWN: begin
                if (count == '0) begin
                    step_count = LIMIT;
                    step_wrap  = 1'b1;
                end else begin
                    step_count = count - ONE;
                end
            end
            MODE_BOUNCE: begin
                // With a zero limit there is nowhere to move: only the
                // direction flips, and every step is a terminal event.
                if (LIMIT == '0) begin
                    step_dir  = ~dir;
                    step_wrap = 1'b1;
                end else if (!dir && count == LIMIT) begin
                    step_dir   = 1'b1;
                    step_count = count - ONE;
                    step_wrap  = 1'b1;
                end else if (dir && count == '0) begin
                    step_dir   = 1'b0;
                    step_count = count + ONE;
                    step_wrap  = 1'b1;
                end else if (dir) begin
                    step_count = count - ONE;
                end else begin
                    step_count = count + ONE;
                end
            end
            MODE_ONESHOT: begin
                // Parks at the limit; only the arriving step is terminal.
                if (count < LIMIT) begin
                    step_count = count + ONE;
                    if (count + ONE == LIMIT) begin
                        step_done = 1'b1;
                        step_wrap = 1'b1;
                    end
                end
            end
            default: begin
                step_count = count;
            end
        endcase
    end

    // Register update: reset beats load, load beats step. dir is pinned by
    // the fixed-direction modes every cycle; bounce keeps whatever dir it
    // inherited and only changes it at the end points.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            presc <= '0;
            dir   <= 1'b0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;

            if (mode == MODE_UP || mode == MODE_ONESHOT) begin
                dir <= 1'b0;
            end else if (mode == MODE_DOWN) begin
                dir <= 1'b1;
            end

            if (mode != MODE_ONESHOT) begin
                done <= 1'b0;
            end

            if (load) begin
                count <= load_clamped;
                presc <= '0;
                done  <= 1'b0;
            end else if (step) begin
                presc <= '0;
                count <= step_count;
                tick  <= (step_count != count);
                wrap  <= step_wrap;
                if (mode == MODE_BOUNCE) begin
                    dir <= step_dir;
                end
                if (step_done) begin
                    done <= 1'b1;
                end
            end else if (en) begin
                presc <= presc + PRESC_WIDTH'(1);
            end
        end
    end

endmodule
